apb_master_ctrl: RTL



---
 rtl/apb_master_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
// ----------------------------------------------------------------------------
// APB master sequencer. Takes one request at a time from the system side,
// runs the two-phase APB protocol (SETUP, ACCESS), waits on PREADY with a
// bounded timeout and hands back read data plus an error status.
// Requests to addresses the decoder flags as unmapped complete with an error
// straight from SETUP and never raise PSEL.
//
// Handshakes: both request and response ports use valid/ready. A transfer
// moves on the rising PCLK edge where valid and ready are both high; valid
// and its payload must hold until that edge, and ready may depend on state
// only.
//
// Ports
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write/addr/wdata/strb request payload
//   rsp_valid/rsp_ready      response handshake (valid only in RESP)
//   rsp_rdata/err/timeout    captured response, held through RESP
//   PADDR..PENABLE           APB master outputs
//   addr_unmapped            decoder "no slot hit" for current PADDR
//   PREADY/PRDATA/PSLVERR    muxed slave returns, sampled only in ACCESS
//   state_dbg                current FSM state (IDLE=0 SETUP=1 ACCESS=2 RESP=3)
// ----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int TIMEOUT = 16  // max ACCESS cycles; 0 disables the timeout
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic        addr_unmapped,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Wait counter is at least one bit wide even when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          tmo_q;
  logic          tmo_expire;

  // Last permitted ACCESS cycle with the slave still not ready.
  assign tmo_expire = (state_q == ACCESS) && !PREADY &&
                      (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ------------------------------------------------------- next state/outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = SETUP;
      end
      SETUP: begin
        // Decoder miss gates the shared select so no slave ever sees the cycle.
        PSEL    = ~addr_unmapped;
        state_d = addr_unmapped ? RESP : ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || tmo_expire) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
            PSTRB  <= req_write ? req_strb : 4'h0;
          end
        end
        SETUP: begin
          if (addr_unmapped) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b0;
          end else begin
            cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            // Writes and errored reads never return slave data.
            rdata_q <= (PWRITE || PSLVERR) ? 32'h0 : PRDATA;
            err_q   <= PSLVERR;
            tmo_q   <= 1'b0;
          end else if (tmo_expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign state_dbg   = state_q;

endmodule
